// File: rtl/img_seq_pkg.sv
// Shared types and width helpers for the image stream sequencer.
package img_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        WAIT_CREDIT,
        SEND_LINE,
        PAD_WAIT,
        PAD_SEND,
        DRAIN
    } state_t;

    // Bits needed to hold the values 0..max_val (never less than 1).
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/intr_credit_counter.sv
// Converts filter interrupt rising edges into line credits; saturates at
// all-ones and latches an overflow flag until the next clear.
module intr_credit_counter #(
    parameter int CREDIT_W = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    input  logic intr,
    input  logic consume,
    output logic available,
    output logic overflow
);

    logic                intr_q;
    logic                rise;
    logic [CREDIT_W-1:0] credit;

    assign rise      = enable & intr & ~intr_q;
    assign available = |credit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            intr_q   <= 1'b0;
            credit   <= '0;
            overflow <= 1'b0;
        end else begin
            intr_q <= intr;
            if (clear) begin
                credit   <= '0;
                overflow <= 1'b0;
            end else if (rise && !consume) begin
                if (&credit) overflow <= 1'b1;
                else         credit   <= credit + 1'b1;
            end else if (!rise && consume) begin
                credit <= credit - 1'b1;
            end
        end
    end

endmodule

// File: rtl/image_stream_sequencer.sv
// Paces a pixel source into the filter: prime lines, one line per interrupt
// credit, zero padding, then waits for all filtered pixels before done.
module image_stream_sequencer
    import img_seq_pkg::*;
#(
    parameter int IMG_WIDTH   = 512,
    parameter int IMG_HEIGHT  = 512,
    parameter int PRIME_LINES = 4,
    parameter int PAD_LINES   = 2,
    parameter int DATA_W      = 8,
    parameter int CREDIT_W    = 3
) (
    input  logic              axi_clk,
    input  logic              axi_reset_n,
    input  logic              i_start,
    input  logic              s_data_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_data_ready,
    output logic              o_pix_valid,
    output logic [DATA_W-1:0] o_pix_data,
    input  logic              i_pix_ready,
    input  logic              i_intr,
    input  logic              i_out_fire,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_credit_err
);

    localparam int COL_W  = cnt_w(IMG_WIDTH - 1);
    localparam int LINE_W = cnt_w(IMG_HEIGHT + PAD_LINES);
    localparam int OUT_W  = cnt_w(IMG_WIDTH * IMG_HEIGHT);

    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IMG_WIDTH - 1);
    localparam logic [LINE_W-1:0] PRIME_LAST = LINE_W'(PRIME_LINES - 1);
    localparam logic [LINE_W-1:0] SRC_LAST   = LINE_W'(IMG_HEIGHT - 1);
    localparam logic [LINE_W-1:0] PAD_LAST   = LINE_W'(IMG_HEIGHT + PAD_LINES - 1);
    localparam logic [OUT_W-1:0]  OUT_TARGET = OUT_W'(IMG_WIDTH * IMG_HEIGHT);

    state_t            state, state_nxt;
    logic [COL_W-1:0]  col_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic [OUT_W-1:0]  out_cnt;
    logic              start, fire, line_end, consume, credit_ok;
    logic              done_q, done_nxt;

    assign start    = (state == IDLE) & i_start;
    assign fire     = o_pix_valid & i_pix_ready;
    assign line_end = fire & (col_cnt == COL_LAST);
    assign consume  = ((state == WAIT_CREDIT) || (state == PAD_WAIT)) & credit_ok;
    assign o_busy   = (state != IDLE);
    assign o_done   = done_q;

    intr_credit_counter #(.CREDIT_W(CREDIT_W)) u_credit (
        .clk       (axi_clk),
        .rst_n     (axi_reset_n),
        .clear     (start),
        .enable    (state != IDLE),
        .intr      (i_intr),
        .consume   (consume),
        .available (credit_ok),
        .overflow  (o_credit_err)
    );

    // Pixel path is a zero-latency mux; only the phase selection is registered.
    always_comb begin
        o_pix_valid  = 1'b0;
        o_pix_data   = '0;
        s_data_ready = 1'b0;
        case (state)
            PRIME, SEND_LINE: begin
                o_pix_valid  = s_data_valid;
                o_pix_data   = s_data;
                s_data_ready = i_pix_ready;
            end
            PAD_SEND: o_pix_valid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE:        if (i_start) state_nxt = PRIME;
            PRIME:       if (line_end && line_cnt == PRIME_LAST) state_nxt = WAIT_CREDIT;
            WAIT_CREDIT: if (credit_ok) state_nxt = SEND_LINE;
            SEND_LINE:   if (line_end) state_nxt = (line_cnt == SRC_LAST) ? PAD_WAIT : WAIT_CREDIT;
            PAD_WAIT:    if (credit_ok) state_nxt = PAD_SEND;
            PAD_SEND:    if (line_end && line_cnt == PAD_LAST) state_nxt = DRAIN;
            DRAIN: begin
                if (out_cnt == OUT_TARGET) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default:     state_nxt = IDLE;
        endcase
    end

    // line_cnt keeps counting through the pad lines so one counter ends both phases.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state    <= IDLE;
            done_q   <= 1'b0;
            col_cnt  <= '0;
            line_cnt <= '0;
            out_cnt  <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
            if (start) begin
                col_cnt  <= '0;
                line_cnt <= '0;
                out_cnt  <= '0;
            end else begin
                if (fire)     col_cnt  <= line_end ? '0 : col_cnt + 1'b1;
                if (line_end) line_cnt <= line_cnt + 1'b1;
                if (state != IDLE && i_out_fire) out_cnt <= out_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_image_stream_sequencer.sv
// Scoreboard bench: random source frames and a behavioural filter model
// drive the sequencer; a negedge monitor checks every transfer and done.
module tb_image_stream_sequencer;
    import img_seq_pkg::*;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int PRM  = 4;
    localparam int PAD  = 2;
    localparam int CW   = 3;
    localparam int NPIX = W * (H + PAD);

    logic       axi_clk = 1'b0;
    logic       axi_reset_n = 1'b0;
    logic       i_start = 1'b0;
    logic       s_data_valid = 1'b0;
    logic [7:0] s_data = '0;
    logic       i_pix_ready = 1'b0;
    logic       i_intr = 1'b0;
    logic       i_out_fire = 1'b0;
    logic       s_data_ready, o_pix_valid, o_busy, o_done, o_credit_err;
    logic [7:0] o_pix_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] src_q[$];
    int rx_pix = 0, out_fired = 0, done_seen = 0, cyc = 0, last_fire_cyc = 0;
    int out_issued = 0, out_pend = 0, intr_timer = 0;
    bit src_take = 0, prev_done = 0, stall = 0, filt_en = 0, src_hold = 0, man_intr = 0;

    always #5 axi_clk = ~axi_clk;

    image_stream_sequencer #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .PRIME_LINES(PRM),
        .PAD_LINES(PAD), .DATA_W(8), .CREDIT_W(CW)
    ) dut (
        .axi_clk      (axi_clk),
        .axi_reset_n  (axi_reset_n),
        .i_start      (i_start),
        .s_data_valid (s_data_valid),
        .s_data       (s_data),
        .s_data_ready (s_data_ready),
        .o_pix_valid  (o_pix_valid),
        .o_pix_data   (o_pix_data),
        .i_pix_ready  (i_pix_ready),
        .i_intr       (i_intr),
        .i_out_fire   (i_out_fire),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_credit_err (o_credit_err)
    );

    task automatic chk(input string name, input longint act, input longint want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, want);
        end
    endtask

    // Monitor: every transfer pops the scoreboard; done is checked for timing.
    always @(negedge axi_clk) begin
        cyc++;
        if (o_pix_valid && i_pix_ready) begin
            chk("col_cnt", dut.col_cnt, rx_pix % W);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_pixel got %0d want none", o_pix_data);
            end else begin
                chk("pix", o_pix_data, exp_q.pop_front());
            end
            rx_pix++;
        end
        src_take = s_data_valid && s_data_ready;
        if (i_out_fire) begin
            out_fired++;
            last_fire_cyc = cyc;
        end
        if (prev_done) chk("done_one_cycle", o_done, 0);
        if (o_done) begin
            chk("busy_at_done", o_busy, 0);
            chk("done_latency", cyc - last_fire_cyc, 2);
            chk("out_fires", out_fired, W * H);
            chk("pix_total", rx_pix, NPIX);
            chk("exp_left", exp_q.size(), 0);
            done_seen++;
        end
        prev_done = o_done;
    end

    // Driver: source queue plus filter model (an output line once three
    // input lines past it have arrived, then an interrupt pulse).
    initial forever begin
        @(posedge axi_clk);
        #1;
        if (src_take && src_q.size() > 0) void'(src_q.pop_front());
        s_data_valid = (src_q.size() > 0) && !src_hold && (!stall || $urandom_range(1) == 1);
        s_data       = (src_q.size() > 0) ? src_q[0] : 8'($urandom);
        i_pix_ready  = !stall || $urandom_range(1) == 1;
        if (filt_en && out_pend == 0 && out_issued < H && rx_pix / W >= out_issued + 3) begin
            out_pend = W;
            out_issued++;
        end
        i_out_fire = (out_pend > 0) && (!stall || $urandom_range(1) == 1);
        i_intr     = man_intr || (intr_timer > 0);
        if (intr_timer > 0) intr_timer--;
        if (i_out_fire) begin
            out_pend--;
            if (out_pend == 0) intr_timer = 2;
        end
    end

    task automatic frame_begin(input bit stl, input bit fen, input bit hold);
        logic [7:0] b;
        stall = stl; filt_en = fen; src_hold = hold;
        src_q.delete(); exp_q.delete();
        rx_pix = 0; out_fired = 0; out_issued = 0; out_pend = 0; intr_timer = 0; done_seen = 0;
        for (int i = 0; i < W * H; i++) begin
            b = 8'($urandom);
            src_q.push_back(b);
            exp_q.push_back(b);
        end
        for (int i = 0; i < W * PAD; i++) exp_q.push_back(8'h00);
        @(posedge axi_clk); #2 i_start = 1'b1;
        @(posedge axi_clk); #2 i_start = 1'b0;
    endtask

    task automatic pulse_intr();
        @(posedge axi_clk); #2 man_intr = 1'b1;
        @(posedge axi_clk); #2 man_intr = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_pix < n && k < budget) begin
            @(posedge axi_clk); #3;
            k++;
        end
        chk("rx_reached", rx_pix >= n, 1);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_seen == 0 && k < budget) begin
            @(posedge axi_clk); #3;
            k++;
        end
        repeat (3) @(posedge axi_clk);
        #3;
        chk("done_count", done_seen, 1);
        chk("idle_after_done", dut.state, IDLE);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge axi_clk);
        #3;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_credit_err, 0);
        chk("rst_pix_valid", o_pix_valid, 0);
        chk("rst_src_ready", s_data_ready, 0);
        chk("rst_state", dut.state, IDLE);
        #11 axi_reset_n = 1'b1;

        // Prime with no interrupts, then let the filter run the whole frame
        frame_begin(0, 0, 0);
        chk("busy_after_start", o_busy, 1);
        wait_rx(W * PRM, 200);
        settle(5);
        chk("prime_pixels", rx_pix, W * PRM);
        chk("prime_state", dut.state, WAIT_CREDIT);
        chk("prime_pix_valid", o_pix_valid, 0);
        chk("prime_src_ready", s_data_ready, 0);
        filt_en = 1;
        wait_done(2000);

        // Interrupts arriving during prime become banked credit
        frame_begin(0, 0, 0);
        pulse_intr();
        pulse_intr();
        settle(1);
        chk("early_credit", dut.u_credit.credit, 2);
        chk("early_still_prime", dut.state, PRIME);
        wait_rx(W * (PRM + 2), 300);
        settle(5);
        chk("early_pixels", rx_pix, W * (PRM + 2));
        chk("early_credit_used", dut.u_credit.credit, 0);
        chk("early_state", dut.state, WAIT_CREDIT);
        filt_en = 1;
        wait_done(2000);

        // Eight edges with nothing consumed overflow a 3-bit counter
        frame_begin(0, 0, 1);
        for (int i = 0; i < 8; i++) pulse_intr();
        settle(1);
        chk("ovf_credit", dut.u_credit.credit, 7);
        chk("ovf_err", o_credit_err, 1);
        chk("ovf_no_pixels", rx_pix, 0);
        src_hold = 0;
        filt_en = 1;
        wait_done(2000);
        chk("ovf_err_sticky", o_credit_err, 1);

        // Random stalls on both sides; a start pulse mid-frame is ignored
        frame_begin(1, 1, 0);
        chk("err_cleared_on_start", o_credit_err, 0);
        settle(30);
        #0 i_start = 1'b1;
        settle(1);
        i_start = 1'b0;
        chk("busy_through_restart", o_busy, 1);
        wait_done(5000);

        // Asynchronous reset part way through a prime line
        frame_begin(0, 0, 0);
        wait_rx(13, 100);
        axi_reset_n = 1'b0;
        #1;
        chk("mid_rst_pix_valid", o_pix_valid, 0);
        chk("mid_rst_src_ready", s_data_ready, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_done", o_done, 0);
        chk("mid_rst_col", dut.col_cnt, 0);
        #3 axi_reset_n = 1'b1;
        frame_begin(0, 0, 0);
        wait_rx(W * PRM, 200);
        settle(5);
        chk("reprime_pixels", rx_pix, W * PRM);
        chk("reprime_state", dut.state, WAIT_CREDIT);
        filt_en = 1;
        wait_done(2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
